// File: rtl/averager_ctrl.sv
// averager_ctrl
// Read-modify-write sequencer for the frame-averaging low-pass path.
//
// For each camera pixel it does three things:
//   1. reads the stored running sum from the single-port frame store;
//   2. presents the old sum and the new RGB to an external combinational
//      weighted averager;
//   3. writes the averager result back.
// The same frame-store port is shared with the VGA scan-out reader through a
// round-robin arbiter.
//
// Optional build macro: AVG_SEED_FIRST_EN
//   When defined, the first frame after reset skips the read and writes the
//   raw pixel, which seeds the store. Seeding ends at the first oFrameDone.
//
// Ports:
//   iCLK, iRST                  clock; asynchronous active-high reset
//   iFrameStart                 the next accepted pixel restarts at address 0
//   iPixValid/oPixReady, iRed/iGreen/iBlue
//                               camera pixel handshake
//   oAvgRed/Green/Blue, oAvgOld registered operands to the averager
//   iAvgNew                     averager result (combinational from oAvg*)
//   oMemAddr/oMemRd/oMemWr/oMemWData/iMemWait/iMemRData/iMemRValid
//                               frame-store command port
//   iVgaReq/iVgaAddr/oVgaGrant/oVgaData/oVgaValid
//                               VGA read requester
//   oFrameDone                  pulses after the write to the last pixel
module averager_ctrl #(
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFrameStart,
  input  logic              iPixValid,
  input  logic [4:0]        iRed,
  input  logic [4:0]        iGreen,
  input  logic [4:0]        iBlue,
  output logic              oPixReady,
  output logic [4:0]        oAvgRed,
  output logic [4:0]        oAvgGreen,
  output logic [4:0]        oAvgBlue,
  output logic [15:0]       oAvgOld,
  input  logic [15:0]       iAvgNew,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemRd,
  output logic              oMemWr,
  output logic [15:0]       oMemWData,
  input  logic              iMemWait,
  input  logic [15:0]       iMemRData,
  input  logic              iMemRValid,
  input  logic              iVgaReq,
  input  logic [ADDR_W-1:0] iVgaAddr,
  output logic              oVgaGrant,
  output logic [15:0]       oVgaData,
  output logic              oVgaValid,
  output logic              oFrameDone
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE, VGA_RD, VGA_WAIT, PIX_RD, PIX_WAIT, PIX_WR
  } state_t;

  state_t            state_q, state_d;
  logic              pix_pend_q, pix_pend_d;
  logic              pix_ready_q, pix_ready_d;
  logic              last_pix_q, last_pix_d;   // 1: pixel won the last arbitration
  logic              restart_q, restart_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;   // address of the current/next pixel
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [4:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [15:0]       avg_old_q, avg_old_d;
  logic [15:0]       vga_data_q, vga_data_d;
  logic              vga_valid_q, vga_valid_d;
  logic              frame_done_q, frame_done_d;

  logic pix_accept;
  logic wr_accept;
  logic wrap;
  logic seeding;

  assign pix_accept = iPixValid && pix_ready_q;
  assign wr_accept  = (state_q == PIX_WR) && !iMemWait;
  assign wrap       = (addr_cnt_q == LAST_ADDR);

`ifdef AVG_SEED_FIRST_EN
  logic seed_q, seed_d;

  // Seeding lasts until the wrapping write of the first frame.
  assign seed_d  = seed_q && !(wr_accept && wrap);
  assign seeding = seed_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) seed_q <= 1'b1;
    else      seed_q <= seed_d;
  end
`else
  assign seeding = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pix_pend_d   = pix_pend_q;
    last_pix_d   = last_pix_q;
    restart_d    = restart_q;
    addr_cnt_d   = addr_cnt_q;
    mem_addr_d   = mem_addr_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    avg_old_d    = avg_old_q;
    vga_data_d   = vga_data_q;
    vga_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    oMemRd       = 1'b0;
    oMemWr       = 1'b0;
    oMemWData    = 16'd0;
    oVgaGrant    = 1'b0;

    if (iFrameStart) restart_d = 1'b1;

    // A pixel is only accepted while none is pending, so the counter is
    // free here. A restart (already flagged or arriving now) is consumed.
    if (pix_accept) begin
      red_d      = iRed;
      green_d    = iGreen;
      blue_d     = iBlue;
      pix_pend_d = 1'b1;
      if (restart_q || iFrameStart) begin
        addr_cnt_d = '0;
        restart_d  = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        // Round robin: VGA wins when it is alone, or when the pixel won last.
        if (iVgaReq && (!pix_pend_q || last_pix_q)) begin
          state_d    = VGA_RD;
          mem_addr_d = iVgaAddr;
          last_pix_d = 1'b0;
        end else if (pix_pend_q) begin
          state_d    = PIX_RD;
          mem_addr_d = addr_cnt_q;
          last_pix_d = 1'b1;
        end
      end
      VGA_RD: begin
        oMemRd = 1'b1;
        if (!iMemWait) begin
          oVgaGrant = 1'b1;
          state_d   = VGA_WAIT;
        end
      end
      VGA_WAIT: begin
        if (iMemRValid) begin
          vga_data_d  = iMemRData;
          vga_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      PIX_RD: begin
        if (seeding) begin
          state_d = PIX_WR;
        end else begin
          oMemRd = 1'b1;
          if (!iMemWait) state_d = PIX_WAIT;
        end
      end
      PIX_WAIT: begin
        if (iMemRValid) begin
          avg_old_d = iMemRData;
          state_d   = PIX_WR;
        end
      end
      PIX_WR: begin
        oMemWr = 1'b1;
        // Write data comes from registered operands, so it stays stable
        // through a stall. Bit 15 of the averager result is don't-care and
        // is forced to zero.
        if (seeding) oMemWData = {1'b0, red_q, green_q, blue_q};
        else         oMemWData = {iAvgNew[15] & 1'b0, iAvgNew[14:0]};
        if (!iMemWait) begin
          state_d    = IDLE;
          pix_pend_d = 1'b0;
          if (wrap) begin
            addr_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            addr_cnt_d = addr_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    pix_ready_d = !pix_pend_d;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= IDLE;
      pix_pend_q   <= 1'b0;
      pix_ready_q  <= 1'b0;
      last_pix_q   <= 1'b1;
      restart_q    <= 1'b0;
      addr_cnt_q   <= '0;
      mem_addr_q   <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      avg_old_q    <= '0;
      vga_data_q   <= '0;
      vga_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_pend_q   <= pix_pend_d;
      pix_ready_q  <= pix_ready_d;
      last_pix_q   <= last_pix_d;
      restart_q    <= restart_d;
      addr_cnt_q   <= addr_cnt_d;
      mem_addr_q   <= mem_addr_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      avg_old_q    <= avg_old_d;
      vga_data_q   <= vga_data_d;
      vga_valid_q  <= vga_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign oPixReady  = pix_ready_q;
  assign oAvgRed    = red_q;
  assign oAvgGreen  = green_q;
  assign oAvgBlue   = blue_q;
  assign oAvgOld    = avg_old_q;
  assign oMemAddr   = mem_addr_q;
  assign oVgaData   = vga_data_q;
  assign oVgaValid  = vga_valid_q;
  assign oFrameDone = frame_done_q;

endmodule

// File: tb/tb_averager_ctrl.sv
`timescale 1ns/1ps
module tb_averager_ctrl;
  localparam int AW  = 4;
  localparam int FP  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          iFrameStart = 1'b0, iPixValid = 1'b0;
  logic [4:0]    iRed = '0, iGreen = '0, iBlue = '0;
  logic          oPixReady;
  logic [4:0]    oAvgRed, oAvgGreen, oAvgBlue;
  logic [15:0]   oAvgOld, iAvgNew;
  logic [AW-1:0] oMemAddr;
  logic          oMemRd, oMemWr;
  logic [15:0]   oMemWData;
  logic          iMemWait = 1'b0;
  logic [15:0]   iMemRData = '0;
  logic          iMemRValid = 1'b0;
  logic          iVgaReq = 1'b0;
  logic [AW-1:0] iVgaAddr = '0;
  logic          oVgaGrant;
  logic [15:0]   oVgaData;
  logic          oVgaValid, oFrameDone;

  averager_ctrl #(.ADDR_W(AW), .FRAME_PIXELS(FP)) dut (
    .iCLK(clk), .iRST(rst), .iFrameStart(iFrameStart), .iPixValid(iPixValid),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .oPixReady(oPixReady),
    .oAvgRed(oAvgRed), .oAvgGreen(oAvgGreen), .oAvgBlue(oAvgBlue),
    .oAvgOld(oAvgOld), .iAvgNew(iAvgNew), .oMemAddr(oMemAddr), .oMemRd(oMemRd),
    .oMemWr(oMemWr), .oMemWData(oMemWData), .iMemWait(iMemWait),
    .iMemRData(iMemRData), .iMemRValid(iMemRValid), .iVgaReq(iVgaReq),
    .iVgaAddr(iVgaAddr), .oVgaGrant(oVgaGrant), .oVgaData(oVgaData),
    .oVgaValid(oVgaValid), .oFrameDone(oFrameDone)
  );

  // Weighted averager model, weight 2^-2: out = (3*old + new) / 4 per channel.
  function automatic logic [15:0] avg_fn(input logic [4:0] r, g, b, input logic [15:0] old);
    logic [6:0] nr, ng, nb;
    nr = (7'(old[14:10]) * 7'd3 + 7'(r)) >> 2;
    ng = (7'(old[9:5])   * 7'd3 + 7'(g)) >> 2;
    nb = (7'(old[4:0])   * 7'd3 + 7'(b)) >> 2;
    avg_fn = {1'b0, nr[4:0], ng[4:0], nb[4:0]};
  endfunction

  // Bit 15 is driven high so the write path must clear it.
  assign iAvgNew = avg_fn(oAvgRed, oAvgGreen, oAvgBlue, oAvgOld) | 16'h8000;

  typedef struct { logic [4:0] r, g, b; logic [AW-1:0] addr; } pix_vec_t;
  typedef struct { logic [AW-1:0] addr; logic [15:0] data; } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [15:0] vga_q[$];
  bit          read_log[$];   // 1 = VGA read, 0 = pixel read
  logic [15:0] mem [0:15];

  int pass_cnt = 0, total_cnt = 0;
  int wr_cnt = 0, rd_total = 0, done_cnt = 0, done_at_wr = -1;
  int bus_err = 0, rd_pend = 0, stall_left = 0, stall_err = 0, stall_seen = 0;
  int seed_left = 0;
  bit stall_arm = 0, log_en = 0;
  logic [AW-1:0] rd_addr = '0, stall_addr = '0;
  logic [15:0]   stall_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Frame-store responder: fixed read latency, optional 5-cycle write stall.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = (i >= 8) ? 16'hA000 + 16'(i) : 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rd_pend = 0; iMemRValid = 1'b0; stall_left = 0; iMemWait = 1'b0;
        continue;
      end
      iMemRValid = 1'b0;
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) begin iMemRValid = 1'b1; iMemRData = mem[rd_addr]; end
      end
      if (stall_arm && oMemWr) begin
        stall_arm = 0; stall_left = 5; stall_addr = oMemAddr; stall_data = oMemWData;
      end
      iMemWait = (stall_left > 0);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        stall_seen++;
        if (!oMemWr || oMemAddr !== stall_addr || oMemWData !== stall_data) stall_err++;
      end
      if (oMemRd && oMemWr) bus_err++;
      if (oMemRd && !iMemWait) begin
        if (rd_pend != 0 || iMemRValid) bus_err++;
        rd_pend = LAT; rd_addr = oMemAddr; rd_total++;
        if (log_en) read_log.push_back(oVgaGrant);
      end
      if (oMemWr && !iMemWait) begin
        wr_cnt++;
        if (wr_q.size() == 0) fail_now("wr_unexpected");
        else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("wr_addr", 32'(oMemAddr), 32'(e.addr));
          check("wr_data", 32'(oMemWData), 32'(e.data));
          $display("write addr=%0d data=0x%04h (expected addr=%0d data=0x%04h)",
                   oMemAddr, oMemWData, e.addr, e.data);
        end
        mem[oMemAddr] = oMemWData;
      end
    end
  end

  // VGA return and frame-done monitors.
  initial forever begin
    tick();
    if (oVgaValid) begin
      if (vga_q.size() == 0) fail_now("vga_unexpected");
      else begin
        logic [15:0] ev;
        ev = vga_q.pop_front();
        check("vga_data", 32'(oVgaData), 32'(ev));
        $display("vga read data=0x%04h (expected 0x%04h)", oVgaData, ev);
      end
    end
    if (oFrameDone) begin done_cnt++; done_at_wr = wr_cnt; end
  end

  task automatic send_pixel(input logic [4:0] r, g, b, input logic [AW-1:0] addr);
    int n;
    wr_exp_t e;
    n = 0;
    while (!oPixReady && n < 300) begin tick(); n++; end
    if (!oPixReady) begin fail_now("pix_ready_timeout"); return; end
    iPixValid = 1'b1; iRed = r; iGreen = g; iBlue = b;
    e.addr = addr;
    if (seed_left > 0) begin e.data = {1'b0, r, g, b}; seed_left--; end
    else e.data = avg_fn(r, g, b, mem[addr]);
    wr_q.push_back(e);
    tick();
    iPixValid = 1'b0;
  endtask

  task automatic vga_read(input logic [AW-1:0] a);
    int n;
    n = 0;
    iVgaReq = 1'b1; iVgaAddr = a;
    vga_q.push_back(mem[a]);
    do begin tick(); n++; end while (!oVgaGrant && n < 300);
    if (!oVgaGrant) fail_now("vga_grant_timeout");
    tick();
    iVgaReq = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    int n;
    n = 0;
    while (wr_cnt < target && n < 500) begin tick(); n++; end
    if (wr_cnt < target) fail_now("write_timeout");
  endtask

  initial begin
    pix_vec_t vecs[5];
    int base, n;
    vecs[0] = '{r: 5'd31, g: 5'd0,  b: 5'd16, addr: 4'd0};
    vecs[1] = '{r: 5'd8,  g: 5'd12, b: 5'd20, addr: 4'd1};
    vecs[2] = '{r: 5'd31, g: 5'd31, b: 5'd31, addr: 4'd2};
    vecs[3] = '{r: 5'd4,  g: 5'd3,  b: 5'd1,  addr: 4'd3};
    vecs[4] = '{r: 5'd31, g: 5'd0,  b: 5'd16, addr: 4'd0};
`ifdef AVG_SEED_FIRST_EN
    seed_left = FP;
`endif

    // Reset state.
    tick(); tick();
    check("rst_pix_ready", 32'(oPixReady), 0);
    check("rst_mem_rd", 32'(oMemRd), 0);
    check("rst_mem_wr", 32'(oMemWr), 0);
    check("rst_mem_addr", 32'(oMemAddr), 0);
    check("rst_wdata", 32'(oMemWData), 0);
    check("rst_avg_old", 32'(oAvgOld), 0);
    check("rst_vga", 32'({oVgaGrant, oVgaValid, oFrameDone}), 0);
    rst = 1'b0;
    tick();
    check("pix_ready_after_rst", 32'(oPixReady), 1);

    // Table: five pixels through a 4-pixel frame, wrapping once.
    for (int i = 0; i < 5; i++) send_pixel(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].addr);
    wait_writes(5);
    tick(); tick();
    check("frame_done_count", 32'(done_cnt), 1);
    check("frame_done_after_wr", 32'(done_at_wr), 4);
`ifdef AVG_SEED_FIRST_EN
    check("reads_seeded", 32'(rd_total), 1);
    check("mem0", 32'(mem[0]), 32'h7C10);
    check("mem1", 32'(mem[1]), 32'h2194);
    check("mem2", 32'(mem[2]), 32'h7FFF);
    check("mem3", 32'(mem[3]), 32'h1061);
`else
    check("reads_rmw", 32'(rd_total), 5);
    check("mem0", 32'(mem[0]), 32'h3407);
    check("mem1", 32'(mem[1]), 32'h0865);
    check("mem2", 32'(mem[2]), 32'h1CE7);
    check("mem3", 32'(mem[3]), 32'h0400);
`endif
    check("ready_idle", 32'(oPixReady), 1);

    // Write stalled five cycles: stable command, one write.
    base = wr_cnt;
    stall_arm = 1;
    send_pixel(5'd10, 5'd20, 5'd30, 4'd1);
    wait_writes(base + 1);
    tick(); tick(); tick();
    check("stall_cycles", 32'(stall_seen), 5);
    check("stall_stable", 32'(stall_err), 0);
    check("stall_one_write", 32'(wr_cnt - base), 1);

    // Frame start while the addr-2 pixel waits for read data.
    send_pixel(5'd1, 5'd2, 5'd3, 4'd2);
    n = 0;
    while (!(oMemRd && !iMemWait) && n < 300) begin tick(); n++; end
    if (n >= 300) fail_now("read_timeout");
    tick();
    iFrameStart = 1'b1;
    tick();
    iFrameStart = 1'b0;
    send_pixel(5'd9, 5'd9, 5'd9, 4'd0);

    // Frame start coincident with the write acceptance of the addr-1 pixel.
    send_pixel(5'd17, 5'd5, 5'd28, 4'd1);
    n = 0;
    while (!(oMemWr && !iMemWait) && n < 300) begin tick(); n++; end
    if (n >= 300) fail_now("write_wait_timeout");
    iFrameStart = 1'b1;
    tick();
    iFrameStart = 1'b0;
    send_pixel(5'd22, 5'd11, 5'd6, 4'd0);
    wait_writes(wr_cnt + 1);
    tick(); tick();

    // Both requesters held: grants must alternate.
    log_en = 1;
    fork
      begin
        send_pixel(5'd3, 5'd6, 5'd9, 4'd1);
        send_pixel(5'd12, 5'd15, 5'd18, 4'd2);
        send_pixel(5'd21, 5'd24, 5'd27, 4'd3);
        send_pixel(5'd30, 5'd1, 5'd2, 4'd0);
      end
      begin
        for (int k = 0; k < 4; k++) vga_read(AW'(8 + k));
      end
    join
    n = 0;
    while ((wr_q.size() != 0 || vga_q.size() != 0) && n < 500) begin tick(); n++; end
    log_en = 0;
    check("alt_reads", 32'(read_log.size()), 8);
    for (int i = 1; i < read_log.size(); i++)
      check("alt_order", 32'(read_log[i] != read_log[i-1]), 1);
    check("frame_done_second", 32'(done_cnt), 2);
    check("wr_queue_empty", 32'(wr_q.size()), 0);
    check("vga_queue_empty", 32'(vga_q.size()), 0);
    check("bus_overlap_outstanding", 32'(bus_err), 0);

    // Reset mid-transaction abandons the pixel at once.
    send_pixel(5'd7, 5'd7, 5'd7, 4'd1);
    n = 0;
    while (!oMemRd && n < 300) begin tick(); n++; end
    rst = 1'b1;
    #1;
    check("async_rst_rd", 32'(oMemRd), 0);
    check("async_rst_ready", 32'(oPixReady), 0);
    wr_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_rerst", 32'(oPixReady), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
